// File: rtl/counter_sweep_pkg.sv
// Shared state encoding and helpers for the triangle-sweep sequencer.
package counter_sweep_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_UP    = 3'd1;
  localparam logic [2:0] ST_DOWN  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  function automatic logic st_is_run(input logic [2:0] st);
    return (st == ST_UP) || (st == ST_DOWN);
  endfunction

endpackage

// File: rtl/sweep_updown_cnt.sv
// Up/down counter with synchronous clear; clear overrides stepping.
module sweep_updown_cnt #(
  parameter int cw = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  input  logic          dir,
  output logic [cw-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= dir ? q + 1'b1 : q - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer running a counter through 0 -> len -> 0 triangle sweeps with
// start/busy/done handshake and stop-to-abort.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int cw = 8,
  parameter int sw = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic [cw-1:0] len,
  input  logic [sw-1:0] sweeps,
  output logic          busy,
  output logic          dir,
  output logic          en,
  output logic [cw-1:0] c_out,
  output logic [sw-1:0] sweep_no,
  output logic          done,
  output logic          aborted
);

  logic [2:0]    state, state_nx;
  logic [cw-1:0] len_q;
  logic [sw-1:0] sweeps_q;
  logic [cw-1:0] c_inc, c_dec;
  logic [sw-1:0] sn_inc;
  logic          accept, run, up_turn, down_end, last_sweep, cnt_en;

  assign accept     = (state == ST_IDLE) && start;
  assign run        = st_is_run(state);
  assign c_inc      = c_out + 1'b1;
  assign c_dec      = c_out - 1'b1;
  assign sn_inc     = sweep_no + 1'b1;
  assign up_turn    = (c_inc == len_q);
  assign down_end   = (c_dec == '0);
  assign last_sweep = (sweeps_q != '0) && (sn_inc == sweeps_q);
  // stop freezes the counter on the same edge that moves the FSM to ABORT
  assign cnt_en     = run && !stop;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (len == '0) ? ST_DONE : ST_UP;
      ST_UP:    if (stop) state_nx = ST_ABORT;
                else if (up_turn) state_nx = ST_DOWN;
      ST_DOWN:  if (stop) state_nx = ST_ABORT;
                else if (down_end) state_nx = last_sweep ? ST_DONE : ST_UP;
      ST_DONE:  state_nx = ST_IDLE;
      ST_ABORT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      sweep_no <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sweep_no <= '0;
      end else if ((state == ST_DOWN) && !stop && down_end) begin
        sweep_no <= sn_inc;
      end
    end
  end

  // run parameters are only consumed while busy, so they need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q    <= len;
      sweeps_q <= sweeps;
    end
  end

  sweep_updown_cnt #(.cw(cw)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .en     (cnt_en),
    .dir    (state == ST_UP),
    .q      (c_out)
  );

  assign busy    = run;
  assign dir     = (state == ST_UP);
  assign en      = run;
  assign done    = (state == ST_DONE);
  assign aborted = (state == ST_ABORT);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: vector table, hand sequences
// and randomized runs against a trajectory-based reference model.
module tb_counter_sweep_ctrl;

  logic       clk, resetn, start, stop;
  logic [7:0] len, sweeps;
  logic       busy, dir, en, done, aborted;
  logic [7:0] c_out, sweep_no;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       busy;
    logic       dir;
    logic       en;
    logic [7:0] c;
    logic [7:0] sn;
    logic       done;
    logic       ab;
  } obs_t;

  typedef struct {
    int L; int S; int ts; bit restart;
    int peak; int sn; bit dn; bit ab; int c_fin; int end_t;
  } vec_t;

  vec_t tbl [8];

  counter_sweep_ctrl #(.cw(8), .sw(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .len(len), .sweeps(sweeps), .busy(busy), .dir(dir), .en(en),
    .c_out(c_out), .sweep_no(sweep_no), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o = {busy, dir, en, c_out, sweep_no, done, aborted};
    return o;
  endfunction

  task automatic chk(input string nm, input int t, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h exp %0h", nm, t, got, exp);
    end
  endtask

  function automatic int tri_val(int L, int t);
    int p;
    p = t % (2 * L);
    return (p <= L) ? p : 2 * L - p;
  endfunction

  function automatic int abort_time(int L, int S, int ts);
    int T;
    T = (S == 0) ? 32'h3fffffff : 2 * L * S;
    return (ts >= 1 && ts - 1 < T) ? ts : 32'h7fffffff;
  endfunction

  // Expected outputs t cycles after the accepting start edge.
  function automatic obs_t model(int L, int S, int ts, int t);
    obs_t e;
    int T, tab, u;
    e = '0;
    if (L == 0) begin
      e.done = (t == 0);
      return e;
    end
    T   = (S == 0) ? 32'h3fffffff : 2 * L * S;
    tab = abort_time(L, S, ts);
    if (t < tab && t < T) begin
      e.busy = 1'b1;
      e.en   = 1'b1;
      e.dir  = ((t % (2 * L)) < L);
      e.c    = 8'(tri_val(L, t));
      e.sn   = 8'(t / (2 * L));
    end else if (t >= tab) begin
      u    = tab - 1;
      e.c  = 8'(tri_val(L, u));
      e.sn = 8'(u / (2 * L));
      e.ab = (t == tab);
    end else begin
      e.sn   = 8'(S);
      e.done = (t == T);
    end
    return e;
  endfunction

  task automatic run_case(input int L, input int S, input int ts, input bit restart,
                          output int peak, output int sn_fin, output bit dn_seen,
                          output bit ab_seen, output int c_fin, output int end_t);
    int T, tab, fin, last;
    obs_t o, e;
    T    = (L == 0) ? 0 : ((S == 0) ? 32'h3fffffff : 2 * L * S);
    tab  = (L == 0) ? 32'h7fffffff : abort_time(L, S, ts);
    fin  = (tab < T) ? tab : T;
    last = ((ts > fin) ? ts : fin) + 2;
    peak = 0; dn_seen = 0; ab_seen = 0; end_t = -1; sn_fin = 0; c_fin = 0;
    @(negedge clk);
    len = 8'(L); sweeps = 8'(S); start = 1'b1; stop = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    len = 8'($urandom); sweeps = 8'($urandom);
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      o = observe();
      e = model(L, S, ts, t);
      chk($sformatf("cycle_L%0d_S%0d", L, S), t, 64'(o), 64'(e));
      if (o.c > peak) peak = o.c;
      if ((o.done || o.ab) && end_t < 0) end_t = t;
      dn_seen |= o.done;
      ab_seen |= o.ab;
      sn_fin = o.sn;
      c_fin  = o.c;
      stop = (ts != 0) && (t + 1 == ts);
      if (restart && t == 2) begin
        start = 1'b1; len = 8'd7; sweeps = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (t < last) @(posedge clk);
    end
    stop = 1'b0; start = 1'b0;
  endtask

  initial begin
    int peak, snf, cf, et;
    bit dn, ab;
    obs_t o;

    tbl[0] = '{3,   1, 0,  1'b0, 3,   1, 1'b1, 1'b0, 0, 6};
    tbl[1] = '{255, 2, 0,  1'b0, 255, 2, 1'b1, 1'b0, 0, 1020};
    tbl[2] = '{0,   1, 0,  1'b0, 0,   0, 1'b1, 1'b0, 0, 0};
    tbl[3] = '{5,   0, 7,  1'b0, 5,   0, 1'b0, 1'b1, 4, 7};
    tbl[4] = '{5,   0, 5,  1'b0, 4,   0, 1'b0, 1'b1, 4, 5};
    tbl[5] = '{1,   3, 0,  1'b0, 1,   3, 1'b1, 1'b0, 0, 6};
    tbl[6] = '{4,   2, 20, 1'b0, 4,   2, 1'b1, 1'b0, 0, 16};
    tbl[7] = '{2,   3, 0,  1'b1, 2,   3, 1'b1, 1'b0, 0, 12};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; len = '0; sweeps = '0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    o = observe();
    chk("reset_outputs", 0, 64'(o), 64'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    o = observe();
    chk("idle_after_reset", 0, 64'(o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_case(tbl[i].L, tbl[i].S, tbl[i].ts, tbl[i].restart, peak, snf, dn, ab, cf, et);
      chk($sformatf("vec%0d_peak", i),  i, 64'(peak), 64'(tbl[i].peak));
      chk($sformatf("vec%0d_sweeps", i), i, 64'(snf), 64'(tbl[i].sn));
      chk($sformatf("vec%0d_done", i),  i, 64'(dn),   64'(tbl[i].dn));
      chk($sformatf("vec%0d_abort", i), i, 64'(ab),   64'(tbl[i].ab));
      chk($sformatf("vec%0d_cfin", i),  i, 64'(cf),   64'(tbl[i].c_fin));
      chk($sformatf("vec%0d_endt", i),  i, 64'(et),   64'(tbl[i].end_t));
    end

    for (int r = 0; r < 12; r++) begin
      int L, S, ts;
      L  = $urandom_range(1, 16);
      S  = $urandom_range(1, 3);
      ts = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * L * S + 2) : 0;
      run_case(L, S, ts, 1'b0, peak, snf, dn, ab, cf, et);
    end

    // asynchronous reset in the middle of a run
    @(negedge clk);
    len = 8'd2; sweeps = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_c", 3, 64'(c_out), 64'd1);
    #1 resetn = 1'b0;
    #1;
    o = observe();
    chk("async_reset_outputs", 0, 64'(o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    o = observe();
    chk("idle_after_midrun_reset", 0, 64'(o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
